// File: rtl/store_buffer_if.sv
// Datapath-side store/load handshake plus the single-port data memory bus.
// The store buffer uses the slave modport; the datapath/memory side uses master.
interface store_buffer_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_fwd;
    logic          flush;
    logic          flush_done;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_read;
    logic          dm_write;
    logic [DW-1:0] dm_rdata;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush, dm_rdata,
        output st_ready, ld_data, ld_fwd, flush_done, dm_addr, dm_wdata, dm_read, dm_write
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, flush, dm_rdata,
        input  st_ready, ld_data, ld_fwd, flush_done, dm_addr, dm_wdata, dm_read, dm_write
    );
endinterface

// File: rtl/store_buffer.sv
// Write-back store FIFO in front of a single-port data memory: forwards loads
// from the youngest matching entry and retires stores whenever no load misses.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic          hit;
    logic [DW-1:0] hit_data;
    logic [PW-1:0] idx;
    logic          miss;
    logic          drain;
    logic          enq;

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (ent_vld[idx] && (ent_addr[idx] == bus.ld_addr)) begin
                hit      = 1'b1;
                hit_data = ent_data[idx];
            end
        end
    end

    assign miss  = bus.ld_valid && !hit;
    assign drain = (count != '0) && !miss;
    assign enq   = bus.st_valid && bus.st_ready;

    assign bus.st_ready   = (count != FULL) && !bus.flush;
    assign bus.flush_done = (count == '0);
    assign bus.ld_fwd     = bus.ld_valid && hit;
    assign bus.dm_read    = miss;
    assign bus.dm_write   = drain;

    always_comb begin
        bus.ld_data  = '0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        if (bus.ld_valid)
            bus.ld_data = hit ? hit_data : bus.dm_rdata;
        if (miss) begin
            bus.dm_addr = bus.ld_addr;
        end else if (drain) begin
            bus.dm_addr  = ent_addr[head];
            bus.dm_wdata = ent_data[head];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ent_vld <= '0;
        end else begin
            // enq and drain never target the same slot: that needs count 0 or DEPTH.
            if (enq) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + PTR_ONE;
            end
            if (drain) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_ONE;
            end
            case ({enq, drain})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset; it is only observed through valid bits.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= bus.st_addr;
            ent_data[tail] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural 8 x 8-bit data memory.
module tb_store_buffer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] mem [8];
    int vectors = 0;
    int miscompares = 0;

    store_buffer_if #(.AW(8), .DW(8)) bus ();

    store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.dm_rdata = mem[bus.dm_addr[2:0]];

    always @(posedge clk) begin
        if (bus.dm_write)
            mem[bus.dm_addr[2:0]] = bus.dm_wdata;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.st_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        mem[1] = 8'h06;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.flush    = 1'b0;

        // Reset then idle
        #12 rst_n = 1'b1;
        #1;
        chk("rst_st_ready",   8'(bus.st_ready),   8'd1);
        chk("rst_flush_done", 8'(bus.flush_done), 8'd1);
        chk("rst_dm_write",   8'(bus.dm_write),   8'd0);
        chk("rst_dm_read",    8'(bus.dm_read),    8'd0);
        chk("rst_ld_data",    bus.ld_data,        8'h00);
        chk("rst_dm_addr",    bus.dm_addr,        8'h00);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd1;
        #1;
        chk("ld1_data",    bus.ld_data,         8'h06);
        chk("ld1_fwd",     8'(bus.ld_fwd),      8'd0);
        chk("ld1_dm_read", 8'(bus.dm_read),     8'd1);
        chk("ld1_dm_addr", bus.dm_addr,         8'd1);
        bus.ld_valid = 1'b0;

        // Single store, drained the next cycle
        store(8'd2, 8'hA5);
        #1;
        chk("s2_dm_write", 8'(bus.dm_write),   8'd1);
        chk("s2_dm_addr",  bus.dm_addr,        8'd2);
        chk("s2_dm_wdata", bus.dm_wdata,       8'hA5);
        chk("s2_busy",     8'(bus.flush_done), 8'd0);
        tick();
        chk("s2_empty",    8'(bus.flush_done), 8'd1);
        chk("s2_idle_wr",  8'(bus.dm_write),   8'd0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd2;
        #1;
        chk("s2_ld_data",  bus.ld_data,        8'hA5);
        chk("s2_ld_fwd",   8'(bus.ld_fwd),     8'd0);

        // Fill while a load miss on 7 holds the port
        bus.ld_addr = 8'd7;
        store(8'd3, 8'h11);
        store(8'd3, 8'h22);
        store(8'd4, 8'h33);
        store(8'd5, 8'h44);
        #1;
        chk("full_st_ready", 8'(bus.st_ready), 8'd0);
        chk("full_dm_read",  8'(bus.dm_read),  8'd1);
        chk("full_dm_write", 8'(bus.dm_write), 8'd0);
        bus.ld_addr = 8'd3;
        #1;
        chk("fwd_ld_data",  bus.ld_data,       8'h22);
        chk("fwd_ld_fwd",   8'(bus.ld_fwd),    8'd1);
        chk("fwd_dm_read",  8'(bus.dm_read),   8'd0);
        chk("fwd_dm_write", 8'(bus.dm_write),  8'd1);
        chk("fwd_dr0_addr", bus.dm_addr,       8'd3);
        chk("fwd_dr0_data", bus.dm_wdata,      8'h11);
        tick();
        bus.ld_valid = 1'b0;
        #1;
        chk("dr_st_ready", 8'(bus.st_ready), 8'd1);
        chk("dr1_addr",    bus.dm_addr,      8'd3);
        chk("dr1_data",    bus.dm_wdata,     8'h22);
        tick();
        chk("dr2_addr",    bus.dm_addr,      8'd4);
        chk("dr2_data",    bus.dm_wdata,     8'h33);
        tick();
        chk("dr3_addr",    bus.dm_addr,      8'd5);
        chk("dr3_data",    bus.dm_wdata,     8'h44);
        tick();
        chk("dr_empty",    8'(bus.flush_done), 8'd1);
        chk("mem3",        mem[3],           8'h22);
        chk("mem4",        mem[4],           8'h33);
        chk("mem5",        mem[5],           8'h44);

        // Load miss and pending store in the same cycle
        store(8'd6, 8'h5A);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd1;
        #1;
        chk("lm_dm_read",  8'(bus.dm_read),  8'd1);
        chk("lm_dm_write", 8'(bus.dm_write), 8'd0);
        chk("lm_dm_addr",  bus.dm_addr,      8'd1);
        chk("lm_ld_data",  bus.ld_data,      8'h06);
        tick();
        bus.ld_valid = 1'b0;
        #1;
        chk("lm_drain_wr",   8'(bus.dm_write), 8'd1);
        chk("lm_drain_addr", bus.dm_addr,      8'd6);
        chk("lm_drain_data", bus.dm_wdata,     8'h5A);
        tick();
        chk("lm_mem6",       mem[6],           8'h5A);

        // Same-address load and store in one cycle sees the old value
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 8'd1;
        bus.st_data  = 8'h77;
        #1;
        chk("sa_ld_data", bus.ld_data,     8'h06);
        chk("sa_ld_fwd",  8'(bus.ld_fwd),  8'd0);
        tick();
        bus.st_valid = 1'b0;
        #1;
        chk("sa_fwd_data", bus.ld_data,      8'h77);
        chk("sa_fwd",      8'(bus.ld_fwd),   8'd1);
        chk("sa_fwd_wr",   8'(bus.dm_write), 8'd1);
        tick();
        chk("sa_mem_data", bus.ld_data,      8'h77);
        chk("sa_mem_fwd",  8'(bus.ld_fwd),   8'd0);

        // Flush with three entries; a store offered during flush is ignored
        bus.ld_addr = 8'd7;
        store(8'd0, 8'h01);
        store(8'd1, 8'h02);
        store(8'd2, 8'h03);
        bus.ld_valid = 1'b0;
        bus.flush    = 1'b1;
        bus.st_valid = 1'b1;
        bus.st_addr  = 8'd7;
        bus.st_data  = 8'hFF;
        #1;
        chk("fl_st_ready", 8'(bus.st_ready),   8'd0);
        chk("fl_done0",    8'(bus.flush_done), 8'd0);
        tick();
        chk("fl_done1",    8'(bus.flush_done), 8'd0);
        tick();
        chk("fl_done2",    8'(bus.flush_done), 8'd0);
        tick();
        chk("fl_done3",    8'(bus.flush_done), 8'd1);
        bus.flush    = 1'b0;
        bus.st_valid = 1'b0;
        tick();
        chk("fl_stay_done", 8'(bus.flush_done), 8'd1);
        chk("fl_mem0",      mem[0],             8'h01);
        chk("fl_mem2",      mem[2],             8'h03);
        chk("fl_mem7",      mem[7],             8'h00);

        // Asynchronous reset with two entries pending
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 8'd7;
        store(8'd4, 8'h99);
        store(8'd5, 8'h98);
        bus.ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_st_ready", 8'(bus.st_ready),   8'd1);
        chk("ar_done",     8'(bus.flush_done), 8'd1);
        chk("ar_dm_write", 8'(bus.dm_write),   8'd0);
        chk("ar_dm_addr",  bus.dm_addr,        8'd0);
        chk("ar_dm_wdata", bus.dm_wdata,       8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_post_wr",  8'(bus.dm_write),   8'd0);
        tick();
        chk("ar_mem4",     mem[4],             8'h33);
        chk("ar_mem5",     mem[5],             8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
